// File: rtl/morse_pkg.sv
// Shared Morse timing definitions: FSM state encoding and the unit-count
// thresholds that the downstream symbol decoder also relies on.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    GAP_L = 2'd3
  } morse_state_t;

  // A mark longer than this many units is a dash.
  localparam int DASH_MIN_UNITS   = 2;
  // A space longer than this many units ends the letter.
  localparam int LETTER_GAP_UNITS = 2;
  // A space longer than this many units ends the word.
  localparam int WORD_GAP_UNITS   = 5;

endpackage

// File: rtl/Dflipflop.sv
// Single D flip-flop with synchronous active-high clear; used as a
// synchroniser stage.
module Dflipflop (
  input  logic Clock,
  input  logic Reset,
  input  logic d,
  output logic q
);

  // Capture d every edge, clear on reset.
  always_ff @(posedge Clock) begin
    if (Reset) q <= 1'b0;
    else       q <= d;
  end

endmodule

// File: rtl/morse_debounce.sv
// Key debouncer: the output level follows the input only after the input
// has held the new level for DEBOUNCE_CYCLES consecutive samples.
module morse_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic din,
  output logic dout
);

  localparam int RW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [RW-1:0] run;

  // Count consecutive samples that disagree with dout; flip once the run is long enough.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      run  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      run  <= '0;
    end else if (run == RW'(DEBOUNCE_CYCLES - 1)) begin
      run  <= '0;
      dout <= din;
    end else begin
      run  <= run + 1'b1;
    end
  end

endmodule

// File: rtl/morse_timing_parser.sv
// Morse key front end: synchronises the key, measures mark/space lengths in
// units of UNIT_CYCLES clocks and emits one-cycle dot/dash/letter_end/word_end
// events. Optional debounce stage enabled by the MORSE_DEBOUNCE_EN macro.
module morse_timing_parser
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES     = 1,
  parameter int CNT_W           = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key,
  output logic dot,
  output logic dash,
  output logic letter_end,
  output logic word_end,
  output logic mark_active
);

  // Reject configurations whose word threshold would not fit the counter.
  if (UNIT_CYCLES < 1) begin : g_bad_unit
    $error("morse_timing_parser: UNIT_CYCLES must be >= 1");
  end
  if ((WORD_GAP_UNITS * UNIT_CYCLES + 1) >= (2 ** CNT_W)) begin : g_bad_cnt
    $error("morse_timing_parser: CNT_W too small for the word gap threshold");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("morse_timing_parser: DEBOUNCE_CYCLES must be >= 1");
  end

  localparam logic [CNT_W-1:0] DOT_MAX   = CNT_W'(DASH_MIN_UNITS * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] LETTER_TH = CNT_W'(LETTER_GAP_UNITS * UNIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WORD_TH   = CNT_W'(WORD_GAP_UNITS * UNIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic s1, key_s, key_f;

  Dflipflop u_sync0 (.Clock(Clock), .Reset(Reset), .d(key), .q(s1));
  Dflipflop u_sync1 (.Clock(Clock), .Reset(Reset), .d(s1),  .q(key_s));

`ifdef MORSE_DEBOUNCE_EN
  morse_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .Clock(Clock),
    .Reset(Reset),
    .din  (key_s),
    .dout (key_f)
  );
`else
  assign key_f = key_s;
`endif

  morse_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             dot_d, dash_d, le_d, we_d;

  // Saturating count: a very long mark/space parks at all-ones.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // Next state, next count and next event pulses from the filtered key.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dot_d   = 1'b0;
    dash_d  = 1'b0;
    le_d    = 1'b0;
    we_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_f) begin
          state_d = MARK;
          cnt_d   = CNT_ONE;
        end
      end
      MARK: begin
        if (key_f) begin
          cnt_d = cnt_inc;
        end else begin
          // A saturated count is above DOT_MAX, so it classifies as a dash.
          if (cnt_q > DOT_MAX) dash_d = 1'b1;
          else                 dot_d  = 1'b1;
          state_d = SPACE;
          cnt_d   = CNT_ONE;
        end
      end
      SPACE: begin
        if (key_f) begin
          state_d = MARK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == LETTER_TH) begin
            le_d    = 1'b1;
            state_d = GAP_L;
          end
        end
      end
      GAP_L: begin
        if (key_f) begin
          state_d = MARK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == WORD_TH) begin
            we_d    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset drops any partial measurement.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dot         <= 1'b0;
      dash        <= 1'b0;
      letter_end  <= 1'b0;
      word_end    <= 1'b0;
      mark_active <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dot         <= dot_d;
      dash        <= dash_d;
      letter_end  <= le_d;
      word_end    <= we_d;
      mark_active <= key_f;
    end
  end

endmodule

// File: tb/tb_morse_timing_parser.sv
// Bench for morse_timing_parser: three configurations share one key stream
// and are compared every cycle against a run-length model of Morse timing.
module tb_morse_timing_parser;

  localparam int DB = 4;

  logic Clock, Reset, key;
  logic [2:0] o_dot, o_dash, o_le, o_we, o_ma;

  morse_timing_parser #(.UNIT_CYCLES(1), .CNT_W(10), .DEBOUNCE_CYCLES(DB)) dut_a (
    .Clock(Clock), .Reset(Reset), .key(key), .dot(o_dot[0]), .dash(o_dash[0]),
    .letter_end(o_le[0]), .word_end(o_we[0]), .mark_active(o_ma[0]));
  morse_timing_parser #(.UNIT_CYCLES(4), .CNT_W(10), .DEBOUNCE_CYCLES(DB)) dut_b (
    .Clock(Clock), .Reset(Reset), .key(key), .dot(o_dot[1]), .dash(o_dash[1]),
    .letter_end(o_le[1]), .word_end(o_we[1]), .mark_active(o_ma[1]));
  morse_timing_parser #(.UNIT_CYCLES(1), .CNT_W(4), .DEBOUNCE_CYCLES(DB)) dut_c (
    .Clock(Clock), .Reset(Reset), .key(key), .dot(o_dot[2]), .dash(o_dash[2]),
    .letter_end(o_le[2]), .word_end(o_we[2]), .mark_active(o_ma[2]));

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit run_chk = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int unit_of(input int i);
    return (i == 1) ? 4 : 1;
  endfunction

  // Model: current run level and length, whether this gap already produced
  // letter_end, and whether we are idle (no gap events until the next mark).
  typedef struct {
    bit idle;
    bit lvl;
    int len;
    bit ldone;
  } mdl_t;

  mdl_t       m [3];
  logic [3:0] exp_ev [3];   // {dot, dash, letter_end, word_end}
  logic       exp_ma;
  bit         d0, d1, kf;
  bit         hist [$];

  task automatic model_step(input mdl_t mi, input int u, input bit s,
                            output mdl_t mo, output logic [3:0] ev);
    mo = mi;
    ev = 4'b0000;
    if (s) begin
      if (mo.idle || !mo.lvl) begin
        mo.idle = 0; mo.lvl = 1; mo.len = 1;
      end else begin
        mo.len++;
      end
    end else if (!mo.idle) begin
      if (mo.lvl) begin
        ev = (mo.len > 2 * u) ? 4'b0100 : 4'b1000;
        mo.lvl = 0; mo.len = 1; mo.ldone = 0;
      end else begin
        mo.len++;
        if (!mo.ldone && mo.len == 2 * u + 1) begin
          ev = 4'b0010; mo.ldone = 1;
        end else if (mo.ldone && mo.len == 5 * u + 1) begin
          ev = 4'b0001; mo.idle = 1;
        end
      end
    end
  endtask

  // Reference update at each edge; d0/d1 is the two-sample input delay.
  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (Reset) begin
      d0 = 0; d1 = 0; kf = 0;
      hist.delete();
      exp_ma = 0;
      for (int i = 0; i < 3; i++) begin
        m[i].idle = 1; m[i].lvl = 0; m[i].len = 0; m[i].ldone = 0;
        exp_ev[i] = 4'b0000;
      end
    end else begin
      bit s, fin;
      s  = d1;
      d1 = d0;
      d0 = key;
`ifdef MORSE_DEBOUNCE_EN
      fin = kf;
      hist.push_back(s);
      if (hist.size() > DB) void'(hist.pop_front());
      if (hist.size() == DB) begin
        bit same;
        same = 1;
        foreach (hist[k]) if (hist[k] != s) same = 0;
        if (same) kf = s;
      end
`else
      fin = s;
`endif
      exp_ma = fin;
      for (int i = 0; i < 3; i++)
        model_step(m[i], unit_of(i), fin, m[i], exp_ev[i]);
    end
  end

  int cnt_ev [3][4];
  int mev_cyc = 0;

  // Per-cycle comparison of every instance against the model.
  always @(negedge Clock) begin
    if (run_chk) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("out%0d", i),
            int'({o_dot[i], o_dash[i], o_le[i], o_we[i], o_ma[i]}),
            int'({exp_ev[i], exp_ma}));
        cnt_ev[i][0] += int'(o_dot[i]);
        cnt_ev[i][1] += int'(o_dash[i]);
        cnt_ev[i][2] += int'(o_le[i]);
        cnt_ev[i][3] += int'(o_we[i]);
      end
      if (o_dot[0] || o_dash[0]) mev_cyc = cyc;
    end
  end

  int base [3][4];

  task automatic snap();
    base = cnt_ev;
  endtask

  task automatic chk_cnt(input string nm, input int i, input int dt, input int ds,
                         input int le, input int we);
    chk({nm, "_dot"},  cnt_ev[i][0] - base[i][0], dt);
    chk({nm, "_dash"}, cnt_ev[i][1] - base[i][1], ds);
    chk({nm, "_le"},   cnt_ev[i][2] - base[i][2], le);
    chk({nm, "_we"},   cnt_ev[i][3] - base[i][3], we);
  endtask

  task automatic drive(input bit v, input int n);
    repeat (n) begin
      key = v;
      @(negedge Clock);
    end
  endtask

  int t_last;

  initial begin
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 4; k++) begin
        cnt_ev[i][k] = 0;
        base[i][k] = 0;
      end
    key = 0;
    Reset = 1;
    repeat (3) @(negedge Clock);
    chk("reset_outs", int'({o_dot, o_dash, o_le, o_we, o_ma}), 0);
    Reset = 0;
    run_chk = 1;
    drive(0, 5);

`ifndef MORSE_DEBOUNCE_EN
    // 1-cycle mark then long space: dot, letter_end, word_end.
    snap();
    drive(1, 1);
    t_last = cyc;
    drive(0, 30);
    chk_cnt("t1_a", 0, 1, 0, 1, 1);
    chk("t1_latency", mev_cyc - t_last, 3);

    // 2-cycle mark, 1-cycle space, 3-cycle mark.
    snap();
    drive(1, 2); drive(0, 1); drive(1, 3); drive(0, 30);
    chk_cnt("t2_a", 0, 1, 1, 1, 1);

    // Unit 4: dot/dash and letter gap boundaries.
    snap();
    drive(1, 8); drive(0, 8); drive(1, 9); drive(0, 9); drive(1, 2); drive(0, 30);
    chk_cnt("t3_b", 1, 2, 1, 2, 1);

    // Narrow counter: long mark saturates and still yields one dash.
    snap();
    drive(1, 40); drive(0, 30);
    chk_cnt("t4_c", 2, 0, 1, 1, 1);

    // Reset in the middle of a held mark.
    snap();
    drive(1, 5);
    Reset = 1;
    drive(1, 3);
    chk("t5_reset_outs", int'({o_dot, o_dash, o_le, o_we, o_ma}), 0);
    Reset = 0;
    drive(1, 4); drive(0, 30);
    chk_cnt("t5_a", 0, 0, 1, 1, 1);
`else
    // Short glitch is filtered out completely.
    snap();
    drive(1, 2); drive(0, 30);
    chk_cnt("t6_glitch", 0, 0, 0, 0, 0);

    // 6-cycle mark survives the filter with its length intact.
    snap();
    drive(1, 6);
    t_last = cyc;
    drive(0, 30);
    chk_cnt("t6_a", 0, 0, 1, 1, 1);
    chk_cnt("t6_b", 1, 1, 0, 1, 1);
    chk("t6_latency", mev_cyc - t_last, 3 + DB);
`endif

    // Random runs with occasional reset pulses.
    for (int r = 0; r < 300; r++) begin
      drive(r[0], int'($urandom_range(1, 30)));
      if ($urandom_range(0, 40) == 0) begin
        Reset = 1;
        drive(key, int'($urandom_range(1, 2)));
        Reset = 0;
      end
    end
    drive(0, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
